// File: rtl/me_pkg.sv
// Shared widths, FSM encoding and pixel helper for the SAD motion-estimation core.
package me_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned BLK_PIX  = 64;
  localparam int unsigned SR       = 8;
  localparam int unsigned NUM_CAND = (2 * SR) * (2 * SR);
  localparam int unsigned SAD_W    = 14;
  localparam int unsigned MV_W     = $clog2(2 * SR);
  localparam int unsigned IDX_W    = $clog2(NUM_CAND);
  localparam int unsigned BLK_W    = PIX_W * BLK_PIX;
  localparam int unsigned GRP      = 8;
  localparam int unsigned PSUM_W   = 11;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic signed [MV_W-1:0] y;
    logic signed [MV_W-1:0] x;
  } mv_t;

  function automatic logic [PIX_W-1:0] pix_at(input logic [BLK_W-1:0] bus, input int unsigned i);
    return bus[i*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/sad8x8_tree.sv
// Three-stage 8x8 SAD pipeline: abs-diff, 8-term partial sums, final sum.
// The motion vector rides alongside the data as sideband.
module sad8x8_tree
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [BLK_W-1:0] cur,
  input  logic [BLK_W-1:0] cand,
  input  mv_t              in_mv,
  output logic             out_valid,
  output logic [SAD_W-1:0] sad,
  output mv_t              out_mv,
  output logic             busy_c
);

  logic [PIX_W-1:0]  ad [BLK_PIX];
  logic [PSUM_W-1:0] ps [GRP];
  logic [PSUM_W-1:0] ps_c [GRP];
  logic [SAD_W-1:0]  sum_c;
  logic              s1_v;
  logic              s2_v;
  mv_t               s1_mv;
  mv_t               s2_mv;

  function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Valid chain; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_v      <= in_valid;
      s2_v      <= s1_v;
      out_valid <= s2_v;
    end
  end

  always_comb begin
    for (int unsigned g = 0; g < GRP; g++) begin
      ps_c[g] = '0;
      for (int unsigned k = 0; k < GRP; k++) begin
        ps_c[g] = ps_c[g] + PSUM_W'(ad[g*GRP + k]);
      end
    end
    sum_c = '0;
    for (int unsigned g = 0; g < GRP; g++) begin
      sum_c = sum_c + SAD_W'(ps[g]);
    end
  end

  // Data stages only load when their input is valid.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int unsigned i = 0; i < BLK_PIX; i++) begin
        ad[i] <= absdiff(pix_at(cur, i), pix_at(cand, i));
      end
      s1_mv <= in_mv;
    end
    if (s1_v) begin
      for (int unsigned g = 0; g < GRP; g++) begin
        ps[g] <= ps_c[g];
      end
      s2_mv <= s1_mv;
    end
    if (s2_v) begin
      sad    <= sum_c;
      out_mv <= s2_mv;
    end
  end

  assign busy_c = s1_v | s2_v | out_valid;

endmodule

// File: rtl/sad_min_search.sv
// Full-search motion estimation: latches a current block, streams 256 candidates
// through the SAD pipeline and reports the earliest minimum-SAD motion vector.
module sad_min_search
  import me_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cur_valid,
  input  logic [BLK_W-1:0]       cur_data,
  input  logic                   cand_valid,
  output logic                   cand_ready,
  input  logic [BLK_W-1:0]       cand_data,
  output logic                   result_valid,
  output logic [SAD_W-1:0]       best_sad,
  output logic signed [MV_W-1:0] best_mvx,
  output logic signed [MV_W-1:0] best_mvy,
  output logic                   next_block
);

  state_t           state;
  logic [BLK_W-1:0] cur_q;
  logic [IDX_W-1:0] idx;
  logic [SAD_W-1:0] min_sad;
  mv_t              min_mv;
  mv_t              idx_mv;
  logic             accept_c;
  logic             start_c;
  logic             t_valid;
  logic             t_busy_c;
  logic [SAD_W-1:0] t_sad;
  mv_t              t_mv;

  assign accept_c = cand_valid && cand_ready;
  // The DONE cycle doubles as IDLE re-entry so back-to-back blocks need no gap cycle.
  assign start_c  = cur_valid && ((state == IDLE) || (state == DONE));

  always_comb begin
    idx_mv.x = idx[MV_W-1:0] - MV_W'(SR);
    idx_mv.y = idx[IDX_W-1:MV_W] - MV_W'(SR);
  end

  always_ff @(posedge clk) begin
    if (start_c) begin
      cur_q <= cur_data;
    end
  end

  sad8x8_tree u_tree (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept_c),
    .cur      (cur_q),
    .cand     (cand_data),
    .in_mv    (idx_mv),
    .out_valid(t_valid),
    .sad      (t_sad),
    .out_mv   (t_mv),
    .busy_c   (t_busy_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      min_sad      <= '1;
      min_mv       <= '0;
      cand_ready   <= 1'b0;
      result_valid <= 1'b0;
      next_block   <= 1'b0;
      best_sad     <= '0;
      best_mvx     <= '0;
      best_mvy     <= '0;
    end else begin
      result_valid <= 1'b0;
      next_block   <= 1'b0;

      // Strict compare keeps the earliest candidate on ties.
      if (t_valid && (t_sad < min_sad)) begin
        min_sad <= t_sad;
        min_mv  <= t_mv;
      end

      case (state)
        IDLE: begin
          if (cur_valid) begin
            state      <= SEARCH;
            idx        <= '0;
            min_sad    <= '1;
            cand_ready <= 1'b1;
          end
        end
        SEARCH: begin
          if (accept_c) begin
            idx <= idx + IDX_W'(1);
            if (idx == IDX_W'(NUM_CAND - 1)) begin
              state      <= DRAIN;
              cand_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!t_busy_c) begin
            state        <= DONE;
            result_valid <= 1'b1;
            next_block   <= 1'b1;
            best_sad     <= min_sad;
            best_mvx     <= min_mv.x;
            best_mvy     <= min_mv.y;
          end
        end
        DONE: begin
          if (cur_valid) begin
            state      <= SEARCH;
            idx        <= '0;
            min_sad    <= '1;
            cand_ready <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_min_search.sv
// Directed bench for sad_min_search: table of uniform/ramp candidate streams plus
// reset-abort and back-to-back sequences.
module tb_sad_min_search;
  import me_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   cur_valid = 1'b0;
  logic [BLK_W-1:0]       cur_data = '0;
  logic                   cand_valid = 1'b0;
  logic                   cand_ready;
  logic [BLK_W-1:0]       cand_data = '0;
  logic                   result_valid;
  logic [SAD_W-1:0]       best_sad;
  logic signed [MV_W-1:0] best_mvx;
  logic signed [MV_W-1:0] best_mvy;
  logic                   next_block;

  sad_min_search dut (
    .clk         (clk),
    .rst         (rst),
    .cur_valid   (cur_valid),
    .cur_data    (cur_data),
    .cand_valid  (cand_valid),
    .cand_ready  (cand_ready),
    .cand_data   (cand_data),
    .result_valid(result_valid),
    .best_sad    (best_sad),
    .best_mvx    (best_mvx),
    .best_mvy    (best_mvy),
    .next_block  (next_block)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] cur_pix;
    logic [7:0] cand_pix;
    int         sp_idx;
    logic [7:0] sp_pix;
    int         sp2_idx;
    logic [7:0] sp2_pix;
    bit         ramp;
    int         gap;
    int         exp_sad;
    int         exp_mvx;
    int         exp_mvy;
  } vec_t;

  vec_t vecs[6];
  int total = 0;
  int bad = 0;
  int acc, rv, nb, last_cyc, rv_cyc, got_sad, got_mvx, got_mvy;

  function automatic logic [BLK_W-1:0] mk_blk(input logic [7:0] base, input bit ramp);
    logic [BLK_W-1:0] b;
    for (int i = 0; i < 64; i++) b[i*8 +: 8] = base + (ramp ? 8'(i) : 8'd0);
    return b;
  endfunction

  function automatic logic [BLK_W-1:0] cand_for(input vec_t v, input int k);
    if (k == v.sp_idx) return mk_blk(v.sp_pix, v.ramp);
    if (k == v.sp2_idx) return mk_blk(v.sp2_pix, v.ramp);
    return mk_blk(v.cand_pix, v.ramp);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_cand_ready"}, int'(cand_ready), 0);
    check({tag, "_result_valid"}, int'(result_valid), 0);
    check({tag, "_next_block"}, int'(next_block), 0);
    check({tag, "_best_sad"}, int'(best_sad), 0);
    check({tag, "_best_mvx"}, int'(best_mvx), 0);
    check({tag, "_best_mvy"}, int'(best_mvy), 0);
  endtask

  // Drives one block; abort_at >= 0 stops right after that many acceptances.
  task automatic run_block(input vec_t v, input int abort_at);
    int post;
    post = 0; acc = 0; rv = 0; nb = 0; last_cyc = 0; rv_cyc = 0;
    got_sad = -1; got_mvx = 99; got_mvy = 99;
    @(negedge clk);
    cur_data  = mk_blk(v.cur_pix, v.ramp);
    cur_valid = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (result_valid) begin
        rv++;
        rv_cyc  = cyc;
        got_sad = int'(best_sad);
        got_mvx = int'(best_mvx);
        got_mvy = int'(best_mvy);
      end
      if (next_block) nb++;
      if (cand_ready && cur_valid) begin
        cur_valid = 1'b0;
        cur_data  = {16{$urandom}};
      end
      cand_valid = ($urandom_range(99) >= v.gap);
      cand_data  = cand_for(v, acc);
      if (cand_ready && cand_valid) begin
        acc++;
        last_cyc = cyc;
      end
      if (abort_at >= 0 && acc == abort_at) break;
      if (rv > 0) post++;
      if (post > 4) break;
    end
    cand_valid = 1'b0;
  endtask

  task automatic check_block(input string tag, input vec_t v);
    check({tag, "_accepts"}, acc, 256);
    check({tag, "_result_pulses"}, rv, 1);
    check({tag, "_next_pulses"}, nb, 1);
    check({tag, "_sad"}, got_sad, v.exp_sad);
    check({tag, "_mvx"}, got_mvx, v.exp_mvx);
    check({tag, "_mvy"}, got_mvy, v.exp_mvy);
    check({tag, "_latency"}, rv_cyc - last_cyc, 5);
    check({tag, "_ready_after"}, int'(cand_ready), 0);
  endtask

  initial begin
    vec_t bb;
    logic [BLK_W-1:0] blk_b;
    int nres, r1c, r2c, s1, s2, m1x, m1y, m2x, m2y, post;
    bit swapped;

    //           cur    cand   sp   sp_pix sp2  sp2_pix ramp gap sad    mvx mvy
    vecs[0] = '{8'h40, 8'h40, -1,  8'h00, -1,  8'h00,  1'b0, 0,  0,     -8, -8};
    vecs[1] = '{8'h10, 8'h20, 137, 8'h10, -1,  8'h00,  1'b0, 0,  0,      1,  0};
    vecs[2] = '{8'h00, 8'hFF, -1,  8'h00, -1,  8'h00,  1'b0, 0,  16320, -8, -8};
    vecs[3] = '{8'h80, 8'h90, 200, 8'h7F, -1,  8'h00,  1'b0, 30, 64,     0,  4};
    vecs[4] = '{8'h50, 8'h60, 30,  8'h4F, 31,  8'h51,  1'b0, 0,  64,     6, -7};
    vecs[5] = '{8'h00, 8'h05, 255, 8'h01, 254, 8'h03,  1'b1, 10, 64,     7,  7};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b1;

    for (int r = 0; r < 6; r++) begin
      run_block(vecs[r], -1);
      check_block($sformatf("vec%0d", r), vecs[r]);
    end

    // Abort a search mid-stream; best_* still hold the previous nonzero result.
    run_block(vecs[3], 100);
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("abort");
    check("abort_no_result", rv, 0);
    check("abort_no_next", nb, 0);
    @(negedge clk);
    rst = 1'b1;
    run_block(vecs[1], -1);
    check_block("after_abort", vecs[1]);

    // Back-to-back: cur_valid held, second block swapped in during the first search.
    bb = '{8'h3F, 8'h40, 5, 8'h31, -1, 8'h00, 1'b0, 0, 0, 0, 0};
    blk_b = mk_blk(8'h31, 1'b0);
    nres = 0; r1c = 0; r2c = 0; s1 = -1; s2 = -1;
    m1x = 99; m1y = 99; m2x = 99; m2y = 99; post = 0; swapped = 1'b0; acc = 0;
    @(negedge clk);
    cur_data   = mk_blk(bb.cur_pix, 1'b0);
    cur_valid  = 1'b1;
    cand_valid = 1'b1;
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      if (result_valid) begin
        nres++;
        if (nres == 1) begin
          r1c = cyc; s1 = int'(best_sad); m1x = int'(best_mvx); m1y = int'(best_mvy);
        end else begin
          r2c = cyc; s2 = int'(best_sad); m2x = int'(best_mvx); m2y = int'(best_mvy);
          cur_valid = 1'b0;
        end
      end
      if (cand_ready && !swapped) begin
        cur_data = blk_b;
        swapped  = 1'b1;
      end
      cand_data = cand_for(bb, acc % 256);
      if (cand_ready) acc++;
      if (nres >= 2) post++;
      if (post > 3) break;
    end
    cand_valid = 1'b0;
    cur_valid  = 1'b0;
    check("b2b_results", nres, 2);
    check("b2b_spacing", r2c - r1c, 261);
    check("b2b_accepts", acc, 512);
    check("b2b_sad1", s1, 64);
    check("b2b_mvx1", m1x, -8);
    check("b2b_mvy1", m1y, -8);
    check("b2b_sad2", s2, 0);
    check("b2b_mvx2", m2x, -3);
    check("b2b_mvy2", m2y, -8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
